// File: rtl/gb_bus_pkg.sv
// Shared types and constants for the CPU-to-memory bus bridge.
package gb_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } bridge_state_e;

  localparam logic [15:0] HRAM_BASE  = 16'hFF80;
  localparam logic [15:0] HRAM_LAST  = 16'hFFFE;
  localparam logic [7:0]  DI_IDLE    = 8'hFF;
  localparam int unsigned HRAM_DEPTH = 127;
  localparam int unsigned HRAM_AW    = 7;

  // FFFF (interrupt enable) is deliberately excluded and goes to the mem port.
  function automatic logic is_hram(input logic [15:0] addr);
    return (addr >= HRAM_BASE) && (addr <= HRAM_LAST);
  endfunction

endpackage

// File: rtl/gb_hram.sv
// 127x8 single-port high RAM with synchronous write and registered read.
module gb_hram
  import gb_bus_pkg::*;
(
  input  logic               CLK_n,
  input  logic               we,
  input  logic [HRAM_AW-1:0] addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata
);

  logic [7:0] mem [HRAM_DEPTH];

  always_ff @(posedge CLK_n) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/gb_cpu_mem_bridge.sv
// Turns LR35902 strobe-bus memory cycles into req/ack transactions toward the
// memory arbiter, serving HRAM locally without wait states.
module gb_cpu_mem_bridge
  import gb_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic        CLK_n,
  input  logic        RESET,
  input  logic        CLKEN,
  input  logic        MREQ_n,
  input  logic        RD_n,
  input  logic        WR_n,
  input  logic [15:0] A,
  input  logic [7:0]  DO,
  output logic [7:0]  DI,
  output logic        WAIT_n,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  bridge_state_e state_q, state_d;
  logic          strb, strb_q, start;
  logic          hram_rd_q, hram_rd_d;
  logic          hram_we_c;
  logic [7:0]    hram_rdata;
  logic [TW-1:0] cnt_q, cnt_d;
  logic          timeout_hit;
  logic [7:0]    di_d, wdata_d;
  logic          wait_d, req_d, we_d, err_d;
  logic [15:0]   addr_d;
  logic          clken_unused;

  // The bridge runs every clock; the CPU enable is not needed here.
  assign clken_unused = CLKEN;

  assign strb        = !MREQ_n && (!RD_n || !WR_n);
  assign start       = strb && !strb_q;
  assign timeout_hit = (cnt_q + TW'(1)) == TW'(TIMEOUT);

  gb_hram u_hram (
    .CLK_n (CLK_n),
    .we    (hram_we_c),
    .addr  (A[HRAM_AW-1:0]),
    .wdata (DO),
    .rdata (hram_rdata)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_d   = state_q;
    di_d      = DI;
    wait_d    = WAIT_n;
    req_d     = mem_req;
    we_d      = mem_we;
    addr_d    = mem_addr;
    wdata_d   = mem_wdata;
    err_d     = bus_err;
    cnt_d     = cnt_q;
    hram_we_c = 1'b0;
    hram_rd_d = 1'b0;

    // HRAM read data arrives one clock after the start edge.
    if (hram_rd_q) begin
      di_d = hram_rdata;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          if (is_hram(A)) begin
            hram_we_c = !WR_n;
            hram_rd_d = WR_n;
            state_d   = DONE;
          end else begin
            addr_d  = A;
            we_d    = !WR_n;
            wdata_d = DO;
            req_d   = 1'b1;
            wait_d  = 1'b0;
            cnt_d   = '0;
            state_d = REQ;
          end
        end
      end

      // A dropped strobe does not withdraw the request; only ack or timeout end it.
      REQ: begin
        if (mem_ack) begin
          req_d   = 1'b0;
          wait_d  = 1'b1;
          if (!mem_we) begin
            di_d = mem_rdata;
          end
          state_d = strb ? DONE : IDLE;
        end else if (timeout_hit) begin
          req_d   = 1'b0;
          wait_d  = 1'b1;
          di_d    = DI_IDLE;
          err_d   = 1'b1;
          state_d = strb ? DONE : IDLE;
        end else begin
          cnt_d = cnt_q + TW'(1);
        end
      end

      DONE: begin
        if (!strb) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK_n) begin
    if (RESET) begin
      state_q   <= IDLE;
      strb_q    <= 1'b0;
      hram_rd_q <= 1'b0;
      cnt_q     <= '0;
      DI        <= DI_IDLE;
      WAIT_n    <= 1'b1;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      bus_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      strb_q    <= strb;
      hram_rd_q <= hram_rd_d;
      cnt_q     <= cnt_d;
      DI        <= di_d;
      WAIT_n    <= wait_d;
      mem_req   <= req_d;
      mem_we    <= we_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      bus_err   <= err_d;
    end
  end

endmodule
